// File: rtl/arith_pkg.sv
// Shared arithmetic package.
// Holds the default datapath width and the control-FSM state encoding used by
// the bit-serial arithmetic units.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake/result bundle for serial_subtractor.
//   master : controller side (drives start, a, b; observes status/results)
//   slave  : subtractor side
// Signals: start, a[WIDTH], b[WIDTH] -> ; <- busy, done, diff[WIDTH],
//          borrowout, overflow
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrowout;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrowout, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrowout, overflow
  );

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell, gate level.
//   x, y : minuend / subtrahend bit
//   bi   : borrow in
//   d    : difference bit  = x ^ y ^ bi
//   bo   : borrow out      = (~x & y) | (~(x ^ y) & bi)
module full_subtractor_bit (
  input  wire x,
  input  wire y,
  input  wire bi,
  output wire d,
  output wire bo
);

  wire x_xor_y;
  wire x_n;
  wire eq;
  wire b_gen;
  wire b_prop;

  xor u_x0 (x_xor_y, x, y);
  xor u_x1 (d, x_xor_y, bi);
  not u_n0 (x_n, x);
  and u_a0 (b_gen, x_n, y);      // x=0,y=1 always borrows
  not u_n1 (eq, x_xor_y);
  and u_a1 (b_prop, eq, bi);     // equal bits pass the incoming borrow on
  or  u_o0 (bo, b_gen, b_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per
// clock through a single full_subtractor_bit and a borrow flop.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : start/a/b in; busy/done/diff/borrowout/overflow out
// Timing: start accepted in IDLE, WIDTH RUN cycles (busy), one DONE cycle
// (done pulse). Results hold until the next accepted start.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_q;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_msb, b_msb;
  logic             bout_q, ovf_q;
  logic             d, bo;
  logic             accept, last;
  logic             busy_c, done_c;

  full_subtractor_bit u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  assign accept = (state == ST_IDLE) && bus.start;
  assign last   = (state == ST_RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy_c = 1'b1;
        if (cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      diff_q <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      a_msb  <= bus.a[WIDTH-1];
      b_msb  <= bus.b[WIDTH-1];
      diff_q <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == ST_RUN) begin
      // Result bits enter at the MSB so the first bit ends up in diff[0].
      diff_q <= {d, diff_q[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= bo;
      if (last) begin
        bout_q <= bo;
        // d is the sign bit of the result on the final cycle.
        ovf_q  <= (a_msb ^ b_msb) & (d ^ a_msb);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.diff      = diff_q;
  assign bus.borrowout = bout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock through a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the ripple full adder: a minimum-area datapath unit for multi-cycle arithmetic.
- It uses a start/busy/done handshake so a controller can issue operations and collect results.

Parameters:
- WIDTH, 8: operand and result width in bits; minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepted-start cycle only.
- b  input  WIDTH  subtrahend; sampled on the accepted-start cycle only.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; result outputs are valid from this cycle on.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrowout  output  1  unsigned borrow; 1 when a < b unsigned.
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (any state, including mid-RUN):
  - State goes to IDLE; count = 0; borrow flop = 0.
  - busy = 0, done = 0, diff = 0, borrowout = 0, overflow = 0.
  - Any in-flight operation is discarded with no done pulse.
- States:
  - IDLE -> RUN when start = 1.
  - RUN -> DONE when count = WIDTH-1 at the clock edge.
  - DONE -> IDLE unconditionally.
- Accepted start (IDLE, start = 1):
  - Load the a and b shift registers.
  - Capture a[MSB] and b[MSB] for the overflow calculation.
  - Clear the borrow flop and count.
  - Clear diff, borrowout and overflow.
- Each RUN cycle, with x = a_sr[0], y = b_sr[0], bi = borrow:
  - d = x ^ y ^ bi
  - bo = (~x & y) | (~(x ^ y) & bi)
  - The d bit shifts into diff from the MSB end (right shift), so after WIDTH cycles diff[0] holds the first bit computed.
  - a_sr and b_sr shift right by one; borrow <= bo; count increments.
- Final RUN cycle (count = WIDTH-1):
  - borrowout <= bo.
  - overflow is computed from the captured sign bits and the final d bit (the new diff[MSB]).
- DONE: done = 1 for exactly one cycle; busy = 0.
- Latency: start accepted at edge 0; busy high for WIDTH cycles; done high in cycle WIDTH+1.
- diff, borrowout and overflow hold their values until the next accepted start.
- Ignored starts:
  - start in RUN or DONE is ignored and not queued.
  - a and b changes outside the accept cycle have no effect.
- Throughput: back-to-back operations need start in the IDLE cycle after DONE, so one operation per WIDTH+2 cycles.
- a = b gives diff = 0, borrowout = 0, overflow = 0.
- count width is clog2(WIDTH); there is no wrap beyond WIDTH-1.

Decomposition:
- Shared package arith_pkg:
  - State encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - Default width constant ARITH_WIDTH = 8.
- One sub-module, full_subtractor_bit: combinational 1-bit cell (x, y, bi -> d, bo) built from gate primitives, instantiated once.

Test Plan (WIDTH = 8):
- a = 8'd5, b = 8'd3, start pulse -> busy for 8 cycles; done in cycle 9; diff = 8'h02, borrowout = 0, overflow = 0.
- a = 8'd3, b = 8'd5 -> diff = 8'hFE, borrowout = 1, overflow = 0.
- a = 8'h80, b = 8'h01 -> diff = 8'h7F, borrowout = 0, overflow = 1.
- a = 8'h00, b = 8'h80 -> diff = 8'h80, borrowout = 1, overflow = 1.
- Start a = 8'h10, b = 8'h01, then pulse start with a = 8'hFF, b = 8'hFF during RUN cycle 3 -> second request ignored; diff = 8'h0F at done.
- Start a = 8'h40, b = 8'h20, assert reset in RUN cycle 4 -> next cycle all outputs 0 and state IDLE; no done pulse; a fresh start then yields a correct result.
